// File: rtl/dcache_l1_burst_adapter.sv
// L1 data-cache request port to external memory bus adapter: one outstanding request,
// line-aligned burst reads, in-order registered read return. Atomics gated by DCACHE_L1_BURST_AMO_EN.
module dcache_l1_burst_adapter #(
  parameter int LINE_W = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_request,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic              req_rnw,
  input  logic [3:0]        req_be,
  input  logic [4:0]        req_size,
  input  logic              req_is_amo,
  input  logic [4:0]        req_amo,
  output logic              req_ack,
  output logic              rsp_data_valid,
  output logic [31:0]       rsp_data,
  output logic              mem_request,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [4:0]        mem_len,
  output logic              mem_is_amo,
  output logic [4:0]        mem_amo,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = $clog2(LINE_W) + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, ISSUE, READ} state_t;

  state_t            state, state_nxt;
  logic              ack;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_data;
  logic              cap_rnw;
  logic [3:0]        cap_be;
  logic [4:0]        cap_size;
  logic [4:0]        beats_left;
  logic              beat;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt   = state;
    ack         = 1'b0;
    mem_request = 1'b0;
    case (state)
      IDLE:    if (req_request) begin
                 ack       = 1'b1;
                 state_nxt = ISSUE;
               end
      ISSUE: begin
        mem_request = 1'b1;
        if (mem_ready) state_nxt = cap_rnw ? READ : IDLE;
      end
      READ:    if (mem_rvalid && beats_left == 5'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gate with reset so a request held during reset is never acknowledged.
  assign req_ack = ack & rst_n;
  assign beat    = (state == READ) && mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr       <= '0;
      cap_data       <= '0;
      cap_rnw        <= 1'b1;
      cap_be         <= '0;
      cap_size       <= '0;
      beats_left     <= '0;
      rsp_data_valid <= 1'b0;
      rsp_data       <= '0;
    end else begin
      if (ack) begin
        cap_addr <= req_addr;
        cap_data <= req_data;
        cap_rnw  <= req_rnw;
        cap_be   <= req_be;
        // Writes are single-beat only, so their length is forced to zero.
        cap_size <= req_rnw ? req_size : 5'd0;
      end
      if (state == ISSUE && mem_ready)
        beats_left <= cap_size;
      else if (beat && beats_left != 5'd0)
        beats_left <= beats_left - 5'd1;
      rsp_data_valid <= beat;
      if (beat) rsp_data <= mem_rdata;
    end
  end

  assign mem_addr  = (cap_size != 5'd0) ? (cap_addr & LINE_MASK) : cap_addr;
  assign mem_len   = cap_size;
  assign mem_wdata = cap_data;
  assign mem_we    = ~cap_rnw;
  assign mem_be    = cap_be;

`ifdef DCACHE_L1_BURST_AMO_EN
  logic       cap_is_amo;
  logic [4:0] cap_amo;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cap_is_amo <= 1'b0;
      cap_amo    <= '0;
    end else if (ack) begin
      cap_is_amo <= req_is_amo;
      cap_amo    <= req_amo;
    end

  assign mem_is_amo = cap_is_amo;
  assign mem_amo    = cap_amo;
`else
  // Atomics collapse to plain accesses; the opcode inputs are intentionally dropped.
  logic unused_amo;
  assign unused_amo = ^{req_is_amo, req_amo};
  assign mem_is_amo = 1'b0;
  assign mem_amo    = 5'd0;
`endif

endmodule

// File: tb/tb_dcache_l1_burst_adapter.sv
// Scoreboard bench for dcache_l1_burst_adapter: expected commands and read words are queued
// by the stimulus and checked by a negedge monitor.
module tb_dcache_l1_burst_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_request;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_rnw;
  logic [3:0]  req_be;
  logic [4:0]  req_size;
  logic        req_is_amo;
  logic [4:0]  req_amo;
  logic        req_ack;
  logic        rsp_data_valid;
  logic [31:0] rsp_data;
  logic        mem_request;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [4:0]  mem_len;
  logic        mem_is_amo;
  logic [4:0]  mem_amo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  dcache_l1_burst_adapter #(.LINE_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_request(req_request), .req_addr(req_addr), .req_data(req_data), .req_rnw(req_rnw),
    .req_be(req_be), .req_size(req_size), .req_is_amo(req_is_amo), .req_amo(req_amo),
    .req_ack(req_ack), .rsp_data_valid(rsp_data_valid), .rsp_data(rsp_data),
    .mem_request(mem_request), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be), .mem_len(mem_len),
    .mem_is_amo(mem_is_amo), .mem_amo(mem_amo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

`ifdef DCACHE_L1_BURST_AMO_EN
  localparam bit AMO_ON = 1'b1;
`else
  localparam bit AMO_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [4:0]  len;
    logic        is_amo;
    logic [4:0]  amo;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  cmd_t mc;
  rsp_t mr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks every read word and every bus command handshake against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rsp_data_valid) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          mr = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, mr.data);
          chk("rsp_latency_cycle", cyc, mr.cyc);
        end
      end
      if (mem_request && mem_ready) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'd1, 32'd0);
        else begin
          mc = exp_cmd.pop_front();
          chk("cmd_addr", mem_addr, mc.addr);
          chk("cmd_len", {27'd0, mem_len}, {27'd0, mc.len});
          chk("cmd_we", {31'd0, mem_we}, {31'd0, mc.we});
          chk("cmd_be", {28'd0, mem_be}, {28'd0, mc.be});
          chk("cmd_wdata", mem_wdata, mc.wdata);
          chk("cmd_is_amo", {31'd0, mem_is_amo}, {31'd0, mc.is_amo});
          chk("cmd_amo", {27'd0, mem_amo}, {27'd0, mc.amo});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ack"}, {31'd0, req_ack}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_data_valid}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_mem_request"}, {31'd0, mem_request}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, "_mem_len"}, {27'd0, mem_len}, 32'd0);
    chk({tag, "_mem_is_amo"}, {31'd0, mem_is_amo}, 32'd0);
    chk({tag, "_mem_amo"}, {27'd0, mem_amo}, 32'd0);
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic rnw,
                         input logic [3:0] be, input logic [4:0] sz,
                         input logic am, input logic [4:0] op);
    req_addr = a; req_data = d; req_rnw = rnw; req_be = be;
    req_size = sz; req_is_amo = am; req_amo = op; req_request = 1'b1;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] d, input logic we,
                          input logic [3:0] be, input logic [4:0] len,
                          input logic am, input logic [4:0] op);
    cmd_t c;
    c.addr = a; c.wdata = d; c.we = we; c.be = be; c.len = len;
    c.is_amo = AMO_ON ? am : 1'b0;
    c.amo    = AMO_ON ? op : 5'd0;
    exp_cmd.push_back(c);
  endtask

  // Request in IDLE: ack must be immediate and last exactly one cycle.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic rnw,
                        input logic [3:0] be, input logic [4:0] sz,
                        input logic am, input logic [4:0] op, input logic [31:0] exp_addr);
    set_req(a, d, rnw, be, sz, am, op);
    #1;
    chk("req_ack_same_cycle", {31'd0, req_ack}, 32'd1);
    push_cmd(exp_addr, d, ~rnw, be, rnw ? sz : 5'd0, am, op);
    tick;
    req_request = 1'b0;
    #1;
    chk("req_ack_single_cycle", {31'd0, req_ack}, 32'd0);
  endtask

  // Hold mem_ready low for 'stall' cycles, checking the command stays stable, then handshake.
  task automatic issue(input int stall, input bit stray);
    for (int i = 0; i < stall; i++) begin
      chk("hold_request", {31'd0, mem_request}, 32'd1);
      chk("hold_addr", mem_addr, exp_cmd[0].addr);
      chk("hold_wdata", mem_wdata, exp_cmd[0].wdata);
      chk("hold_we", {31'd0, mem_we}, {31'd0, exp_cmd[0].we});
      chk("hold_be", {28'd0, mem_be}, {28'd0, exp_cmd[0].be});
      chk("hold_is_amo", {31'd0, mem_is_amo}, {31'd0, exp_cmd[0].is_amo});
      tick;
    end
    mem_ready = 1'b1;
    if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0BAD_0BAD;
    end
    tick;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    rsp_t r;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    r.data = d;
    r.cyc  = cyc + 1;
    exp_rsp.push_back(r);
    tick;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    set_req(32'h1234, 32'h1, 1'b1, 4'hF, 5'd3, 1'b1, 5'h1);
    #12;
    chk_all_zero("reset");
    req_request = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Line fill from a mid-line address, with one gap between beats.
    do_req(32'h0000_1034, 32'h0, 1'b1, 4'h0, 5'd3, 1'b0, 5'h0, 32'h0000_1030);
    issue(1, 1'b0);
    beat(32'hA0); beat(32'hA1); tick; beat(32'hA2); beat(32'hA3);
    tick;
    chk("fill_done_idle", {31'd0, mem_request}, 32'd0);

    // Back-to-back: next request waits during the last beat, acked with the last rsp pulse.
    do_req(32'h0000_0040, 32'h0, 1'b1, 4'h0, 5'd3, 1'b0, 5'h0, 32'h0000_0040);
    issue(0, 1'b0);
    beat(32'hB0); beat(32'hB1); beat(32'hB2);
    set_req(32'h8000_0008, 32'h0, 1'b1, 4'h0, 5'd0, 1'b0, 5'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hB3;
    mr.data = 32'hB3; mr.cyc = cyc + 1; exp_rsp.push_back(mr);
    #1;
    chk("b2b_no_ack_in_read", {31'd0, req_ack}, 32'd0);
    tick;
    mem_rvalid = 1'b0;
    chk("b2b_ack", {31'd0, req_ack}, 32'd1);
    chk("b2b_last_rsp_valid", {31'd0, rsp_data_valid}, 32'd1);
    push_cmd(32'h8000_0008, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0, 5'h0);
    tick;
    req_request = 1'b0;
    chk("b2b_issue_next", {31'd0, mem_request}, 32'd1);
    // Uncacheable single read; a beat in the handshake cycle must be ignored.
    issue(1, 1'b1);
    beat(32'hDEAD_BEEF);
    tick;

    // Write under three cycles of backpressure.
    do_req(32'h0000_2004, 32'h1234_5678, 1'b0, 4'b0011, 5'd0, 1'b0, 5'h0, 32'h0000_2004);
    issue(3, 1'b0);
    chk("write_idle", {31'd0, mem_request}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h7777;
    tick;
    mem_rvalid = 1'b0;
    tick;
    chk("write_no_rsp", {31'd0, rsp_data_valid}, 32'd0);

    // Atomic read.
    do_req(32'h0000_0300, 32'h0, 1'b1, 4'h0, 5'd0, 1'b1, 5'h01, 32'h0000_0300);
    issue(1, 1'b0);
    beat(32'h55);
    tick;

    // Reset in the middle of a burst.
    do_req(32'h0000_0208, 32'h0, 1'b1, 4'h0, 5'd3, 1'b0, 5'h0, 32'h0000_0200);
    issue(0, 1'b0);
    beat(32'hC0); beat(32'hC1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    set_req(32'h0000_0400, 32'h0, 1'b1, 4'h0, 5'd0, 1'b0, 5'h0);
    #1;
    chk_all_zero("midreset");
    tick; tick;
    req_request = 1'b0;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hC2;
    tick;
    chk("post_reset_no_rsp0", {31'd0, rsp_data_valid}, 32'd0);
    mem_rdata = 32'hC3;
    tick;
    mem_rvalid = 1'b0;
    chk("post_reset_no_rsp1", {31'd0, rsp_data_valid}, 32'd0);
    chk("post_reset_idle", {31'd0, mem_request}, 32'd0);
    tick; tick;

    chk("rsp_queue_drained", exp_rsp.size(), 32'd0);
    chk("cmd_queue_drained", exp_cmd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
